// File: rtl/execute_memory_pipe.sv
// Execute-to-Memory pipeline register with a two-entry main/skid buffer.
// in_ready comes straight from a register. EXMEM_PERF_CNT_EN adds stall/bubble counters.
module execute_memory_pipe #(
    parameter int DATA_W = 16,
    parameter int REG_W  = 4
`ifdef EXMEM_PERF_CNT_EN
    , parameter int CNT_W = 16
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] alu_result_in,
    input  logic [DATA_W-1:0] rd1_in,
    input  logic [REG_W-1:0]  dstReg_in,
    input  logic              zero_in,
    input  logic              reg_write_in,
    input  logic              mem_read_in,
    input  logic              mem_write_in,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] alu_result_out,
    output logic [DATA_W-1:0] rd1_out,
    output logic [REG_W-1:0]  dstReg_out,
    output logic              zero_out,
    output logic              reg_write_out,
    output logic              mem_read_out,
    output logic              mem_write_out
`ifdef EXMEM_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt
`endif
);

    typedef struct packed {
        logic [DATA_W-1:0] alu;
        logic [DATA_W-1:0] rd1;
        logic [REG_W-1:0]  dstReg;
        logic              zero;
        logic              regWrite;
        logic              memRead;
        logic              memWrite;
    } payload_t;

    payload_t r_main;
    payload_t r_skid;
    logic     r_mainValid;
    logic     r_skidValid;

    payload_t w_inPayload;
    logic     w_accept;
    logic     w_outXfer;

    assign w_inPayload = '{alu: alu_result_in, rd1: rd1_in, dstReg: dstReg_in,
                           zero: zero_in, regWrite: reg_write_in,
                           memRead: mem_read_in, memWrite: mem_write_in};
    assign in_ready  = ~r_skidValid;
    assign w_accept  = in_valid & ~r_skidValid;
    assign w_outXfer = r_mainValid & out_ready;

    // A full skid blocks input, so the skid->main move never competes with an accept.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_mainValid <= 1'b0;
            r_skidValid <= 1'b0;
            r_main      <= '0;
            r_skid      <= '0;
        end else if (flush) begin
            r_mainValid <= 1'b0;
            r_skidValid <= 1'b0;
        end else if (r_skidValid) begin
            if (w_outXfer) begin
                r_main      <= r_skid;
                r_skidValid <= 1'b0;
            end
        end else if (w_accept) begin
            if (!r_mainValid || out_ready) begin
                r_main      <= w_inPayload;
                r_mainValid <= 1'b1;
            end else begin
                r_skid      <= w_inPayload;
                r_skidValid <= 1'b1;
            end
        end else if (w_outXfer) begin
            r_mainValid <= 1'b0;
        end
    end

    assign out_valid      = r_mainValid;
    assign alu_result_out = r_main.alu;
    assign rd1_out        = r_main.rd1;
    assign dstReg_out     = r_main.dstReg;
    assign zero_out       = r_main.zero;
    assign reg_write_out  = r_main.regWrite & r_mainValid;
    assign mem_read_out   = r_main.memRead  & r_mainValid;
    assign mem_write_out  = r_main.memWrite & r_mainValid;

`ifdef EXMEM_PERF_CNT_EN
    logic [CNT_W-1:0] r_stallCnt;
    logic [CNT_W-1:0] r_bubbleCnt;

    // Saturating counters; flush deliberately leaves them alone.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stallCnt  <= '0;
            r_bubbleCnt <= '0;
        end else begin
            if (r_mainValid && !out_ready && (r_stallCnt != '1)) begin
                r_stallCnt <= r_stallCnt + CNT_W'(1);
            end
            if (!r_mainValid && (r_bubbleCnt != '1)) begin
                r_bubbleCnt <= r_bubbleCnt + CNT_W'(1);
            end
        end
    end

    assign stall_cnt  = r_stallCnt;
    assign bubble_cnt = r_bubbleCnt;
`endif

endmodule

// File: doc/execute_memory_pipe.md
EXECUTE_MEMORY_PIPE -- requirements
Module: execute_memory_pipe

Interface
REQ-001 Parameter DATA_W, default 16, width of alu_result and rd1 fields.
REQ-002 Parameter REG_W, default 4, width of destination register field.
REQ-003 Parameter CNT_W, default 16, width of performance counters.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, synchronous and active-low.
REQ-006 in_valid  input  1  upstream (Execute) payload valid.
REQ-007 in_ready  output  1  block can accept payload this cycle.
REQ-008 alu_result_in, rd1_in  input  DATA_W each  payload data fields.
REQ-009 dstReg_in  input  REG_W; zero_in, reg_write_in, mem_read_in, mem_write_in  input  1 each  payload control fields.
REQ-010 flush  input  1  discard all held payloads.
REQ-011 out_valid  output  1  downstream (Memory) payload valid.
REQ-012 out_ready  input  1  downstream accepts payload this cycle.
REQ-013 alu_result_out, rd1_out, dstReg_out, zero_out, reg_write_out, mem_read_out, mem_write_out  output  widths as inputs  held payload.
REQ-014 stall_cnt, bubble_cnt  output  CNT_W each  present only with EXMEM_PERF_CNT_EN.

Function
REQ-015 Storage SHALL be two entries: main (drives outputs) and skid; each with its own valid bit.
REQ-016 in_ready SHALL equal NOT skid_valid, taken directly from a register (no combinational path from out_ready).
REQ-017 Transfer in SHALL occur on in_valid AND in_ready; transfer out on out_valid AND out_ready.
REQ-018 Latency: payload accepted in cycle N with main empty or draining SHALL appear on outputs in cycle N+1.
REQ-019 Accept while main holds an unconsumed payload (out_valid AND NOT out_ready): payload SHALL go to skid; in_ready low next cycle.
REQ-020 Output transfer with skid valid: skid SHALL move to main next cycle, skid_valid cleared; simultaneous input impossible (in_ready low).
REQ-021 Simultaneous accept and output transfer with skid empty: new payload SHALL replace main; out_valid stays high.
REQ-022 Payload order SHALL be preserved; no payload duplicated or dropped except by flush.
REQ-023 flush SHALL clear main_valid and skid_valid next cycle, overriding any same-cycle accept or transfer; in_ready high the cycle after.
REQ-024 Data fields SHALL hold their value when not loaded; reg_write_out, mem_read_out, mem_write_out SHALL be ANDed with out_valid.
REQ-025 Outputs SHALL be glitch-free registered values except the three gated control outputs.

Reset
REQ-026 With rst_n low at a clock edge: both valid bits, all data fields and counters SHALL be 0 next cycle; in_ready SHALL be 1.
REQ-027 Reset SHALL override flush and all transfers; reset mid-stall SHALL discard held payloads.

Configuration
REQ-028 Macro EXMEM_PERF_CNT_EN defined: stall_cnt SHALL increment each cycle with out_valid AND NOT out_ready; bubble_cnt each cycle with NOT out_valid; both saturate at 2^CNT_W-1; flush does not clear them.
REQ-029 Macro undefined: stall_cnt, bubble_cnt ports and counter logic SHALL be absent; all other behaviour identical.

Verification
REQ-030 Reset then in_valid=1, alu_result_in=0x1234, dstReg_in=0x5, out_ready=1 -> next cycle out_valid=1, alu_result_out=0x1234, dstReg_out=0x5.
REQ-031 out_ready=0, send A=0x0001 then B=0x0002 -> outputs hold A, in_ready=0; raise out_ready -> A, then B next cycle, then out_valid=0.
REQ-032 Stream 0x0010..0x001F with out_ready=1 and in_valid=1 -> one payload per cycle, in order, in_ready stays 1.
REQ-033 Main and skid full, flush=1 with in_valid=1 -> next cycle out_valid=0, reg_write_out=0, in_ready=1; later payloads flow normally.
REQ-034 EXMEM_PERF_CNT_EN, CNT_W=4, out_valid held with out_ready=0 for 20 cycles -> stall_cnt=15 (saturated), bubble_cnt unchanged.
REQ-035 rst_n=0 for one cycle while stalled with skid full -> out_valid=0, all outputs 0, in_ready=1, counters 0.
